// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// instruction width and the default ack timeout.
package instr_fetch_pkg;

  localparam int INSTR_W         = 32;
  localparam int DEFAULT_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } fetch_state_e;

  // Instruction fetches are legal only on word boundaries.
  function automatic logic word_aligned(input logic [1:0] addr_lo);
    return addr_lo == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// Counts REQ cycles spent waiting for mem_ack; expire_o flags the last
// cycle the fetch FSM is allowed to wait before reporting a timeout.
module fetch_timer
  import instr_fetch_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign expire_o = (count_q == LAST);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch FSM: issues one word read per fetch_start, latches the
// returned word into IR and the fetched address + 4 into PC4.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] pc_i,
  input  logic               fetch_start_i,
  output logic [INSTR_W-1:0] mem_addr_o,
  output logic               mem_req_o,
  input  logic [INSTR_W-1:0] mem_rdata_i,
  input  logic               mem_ack_i,
  output logic [INSTR_W-1:0] ir_o,
  output logic [INSTR_W-1:0] pc4_o,
  output logic               ir_valid_o,
  output logic               busy_o,
  output logic               fetch_err_o,
  output fetch_state_e       state_o
);

  // Memory handshake: mem_req is a level held for the whole REQ state with a
  // stable mem_addr; a single-cycle mem_ack completes it and is ignored in
  // every other state.

  fetch_state_e       state_q;
  logic [INSTR_W-1:0] mem_addr_q;
  logic [INSTR_W-1:0] ir_q;
  logic [INSTR_W-1:0] pc4_q;
  logic [INSTR_W-1:0] pc4_d;
  logic               mem_req_q;
  logic               ir_valid_q;
  logic               fetch_err_q;
  logic               busy_q;
  logic               timer_expire;

  assign pc4_d = mem_addr_q + 32'd4;

  fetch_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (state_q != ST_REQ),
    .enable_i ((state_q == ST_REQ) && !mem_ack_i),
    .expire_o (timer_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      ir_q        <= '0;
      pc4_q       <= '0;
      mem_req_q   <= 1'b0;
      ir_valid_q  <= 1'b0;
      fetch_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      ir_valid_q  <= 1'b0;
      fetch_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fetch_start_i) begin
            busy_q <= 1'b1;
            if (word_aligned(pc_i[1:0])) begin
              mem_addr_q <= pc_i;
              mem_req_q  <= 1'b1;
              state_q    <= ST_REQ;
            end else begin
              fetch_err_q <= 1'b1;
              state_q     <= ST_ERR;
            end
          end
        end
        ST_REQ: begin
          // An ack on the expiry cycle still completes the fetch.
          if (mem_ack_i) begin
            ir_q       <= mem_rdata_i;
            pc4_q      <= pc4_d;
            mem_req_q  <= 1'b0;
            ir_valid_q <= 1'b1;
            state_q    <= ST_DONE;
          end else if (timer_expire) begin
            mem_req_q   <= 1'b0;
            fetch_err_q <= 1'b1;
            state_q     <= ST_ERR;
          end
        end
        ST_DONE, ST_ERR: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_addr_o  = mem_addr_q;
  assign mem_req_o   = mem_req_q;
  assign ir_o        = ir_q;
  assign pc4_o       = pc4_q;
  assign ir_valid_o  = ir_valid_q;
  assign fetch_err_o = fetch_err_q;
  assign busy_o      = busy_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus random
// back-to-back fetches, with a scoreboard of expected {IR, PC4} pairs.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int TIMEOUT = 15;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [INSTR_W-1:0] pc_i = '0;
  logic               fetch_start_i = 1'b0;
  logic [INSTR_W-1:0] mem_addr_o;
  logic               mem_req_o;
  logic [INSTR_W-1:0] mem_rdata_i = '0;
  logic               mem_ack_i = 1'b0;
  logic [INSTR_W-1:0] ir_o;
  logic [INSTR_W-1:0] pc4_o;
  logic               ir_valid_o;
  logic               busy_o;
  logic               fetch_err_o;
  fetch_state_e       state_o;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int exp_valid_cnt = 0;
  int exp_err_cnt = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_ir = '0;
  logic [31:0] model_pc4 = '0;

  instr_fetch #(.TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_i          (pc_i),
    .fetch_start_i (fetch_start_i),
    .mem_addr_o    (mem_addr_o),
    .mem_req_o     (mem_req_o),
    .mem_rdata_i   (mem_rdata_i),
    .mem_ack_i     (mem_ack_i),
    .ir_o          (ir_o),
    .pc4_o         (pc4_o),
    .ir_valid_o    (ir_valid_o),
    .busy_o        (busy_o),
    .fetch_err_o   (fetch_err_o),
    .state_o       (state_o)
  );

  // ---------------- clock / pulse monitor / watchdog ----------------
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (ir_valid_o === 1'b1) valid_cnt++;
      if (fetch_err_o === 1'b1) err_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fetch(input logic [31:0] pc);
    pc_i = pc;
    fetch_start_i = 1'b1;
    tick();
    fetch_start_i = 1'b0;
  endtask

  task automatic pulse_ack(input logic [31:0] rdata);
    mem_rdata_i = rdata;
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] rd;
    logic [63:0] exp;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req_o, ir_valid_o, busy_o, fetch_err_o, state_o} !== 6'b0 ||
        mem_addr_o !== 32'h0 || ir_o !== 32'h0 || pc4_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: req=%b valid=%b busy=%b err=%b state=%0d addr=%h ir=%h pc4=%h, required all zero",
               mem_req_o, ir_valid_o, busy_o, fetch_err_o, state_o, mem_addr_o, ir_o, pc4_o);
    end
    repeat (2) @(posedge clk);
    // Release mid-cycle with fetch_start already up: first edge must accept it.
    @(negedge clk);
    rst_n = 1'b1;
    start_fetch(32'h0000_0100);
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_0100 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL first_fetch_after_reset: req=%b addr=%h busy=%b, required req=1 addr=00000100 busy=1",
               mem_req_o, mem_addr_o, busy_o);
    end
    rd = $urandom();
    exp_q.push_back({rd, 32'h0000_0104});
    exp_valid_cnt++;
    pulse_ack(rd);
    checks++;
    if (ir_valid_o !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL first_fetch_valid: ir_valid=%b, required 1", ir_valid_o);
    end else begin
      exp = exp_q.pop_front();
      if ({ir_o, pc4_o} !== exp) begin
        errors++;
        $display("FAIL first_fetch_data: ir/pc4=%h, required %h", {ir_o, pc4_o}, exp);
      end
      {model_ir, model_pc4} = exp;
    end
    tick();
  endtask

  task automatic test_basic();
    logic [63:0] exp;
    exp_q.push_back({32'h2008_0005, 32'h0040_0004});
    exp_valid_cnt++;
    start_fetch(32'h0040_0000);
    checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0040_0000 || state_o !== ST_REQ) begin
      errors++;
      $display("FAIL basic_req: req=%b addr=%h state=%0d, required req=1 addr=00400000 state=1",
               mem_req_o, mem_addr_o, state_o);
    end
    pc_i = 32'h0DEA_DBE0;
    tick();
    pulse_ack(32'h2008_0005);
    checks++;
    if (ir_valid_o !== 1'b1 || mem_req_o !== 1'b0 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL basic_valid: ir_valid=%b req=%b, required ir_valid=1 req=0", ir_valid_o, mem_req_o);
    end else begin
      exp = exp_q.pop_front();
      if ({ir_o, pc4_o} !== exp || mem_addr_o !== 32'h0040_0000) begin
        errors++;
        $display("FAIL basic_data: ir/pc4=%h addr=%h, required %h addr=00400000", {ir_o, pc4_o}, mem_addr_o, exp);
      end
      {model_ir, model_pc4} = exp;
    end
    tick();
    checks++;
    if (ir_valid_o !== 1'b0 || busy_o !== 1'b0 || state_o !== ST_IDLE) begin
      errors++;
      $display("FAIL basic_return: ir_valid=%b busy=%b state=%0d, required 0 0 IDLE", ir_valid_o, busy_o, state_o);
    end
  endtask

  task automatic test_misaligned();
    start_fetch(32'h0040_0002);
    exp_err_cnt++;
    checks++;
    if (mem_req_o !== 1'b0 || fetch_err_o !== 1'b1 || busy_o !== 1'b1 ||
        ir_o !== model_ir || pc4_o !== model_pc4) begin
      errors++;
      $display("FAIL misaligned_err: req=%b err=%b busy=%b ir=%h pc4=%h, required req=0 err=1 busy=1 ir=%h pc4=%h",
               mem_req_o, fetch_err_o, busy_o, ir_o, pc4_o, model_ir, model_pc4);
    end
    tick();
    checks++;
    if (fetch_err_o !== 1'b0 || mem_req_o !== 1'b0 || state_o !== ST_IDLE) begin
      errors++;
      $display("FAIL misaligned_return: err=%b req=%b state=%0d, required 0 0 IDLE", fetch_err_o, mem_req_o, state_o);
    end
  endtask

  task automatic test_timeout_busy();
    int n;
    start_fetch(32'h0000_1000);
    n = 0;
    while (mem_req_o === 1'b1 && n < 40) begin
      n++;
      // A fetch_start while busy must be dropped, not queued.
      if (n == 5) begin
        pc_i = 32'h0000_2000;
        fetch_start_i = 1'b1;
      end
      tick();
      fetch_start_i = 1'b0;
    end
    exp_err_cnt++;
    checks++;
    if (n != TIMEOUT) begin
      errors++;
      $display("FAIL timeout_req_cycles: mem_req high %0d cycles, required %0d", n, TIMEOUT);
    end
    checks++;
    if (fetch_err_o !== 1'b1 || ir_o !== model_ir || pc4_o !== model_pc4 || mem_addr_o !== 32'h0000_1000) begin
      errors++;
      $display("FAIL timeout_err: err=%b ir=%h pc4=%h addr=%h, required err=1 ir=%h pc4=%h addr=00001000",
               fetch_err_o, ir_o, pc4_o, mem_addr_o, model_ir, model_pc4);
    end
    tick();
    tick();
    checks++;
    if (mem_req_o !== 1'b0 || busy_o !== 1'b0 || fetch_err_o !== 1'b0) begin
      errors++;
      $display("FAIL busy_not_queued: req=%b busy=%b err=%b, required 0 0 0", mem_req_o, busy_o, fetch_err_o);
    end
  endtask

  task automatic test_ack_at_expiry();
    logic [31:0] rd;
    logic [63:0] exp;
    rd = $urandom();
    exp_q.push_back({rd, 32'h0000_3004});
    exp_valid_cnt++;
    start_fetch(32'h0000_3000);
    repeat (TIMEOUT - 1) tick();
    checks++;
    if (mem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL expiry_req_held: req=%b in cycle %0d, required 1", mem_req_o, TIMEOUT);
    end
    pulse_ack(rd);
    checks++;
    if (ir_valid_o !== 1'b1 || fetch_err_o !== 1'b0 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL expiry_ack_wins: ir_valid=%b err=%b, required ir_valid=1 err=0", ir_valid_o, fetch_err_o);
    end else begin
      exp = exp_q.pop_front();
      if ({ir_o, pc4_o} !== exp) begin
        errors++;
        $display("FAIL expiry_data: ir/pc4=%h, required %h", {ir_o, pc4_o}, exp);
      end
      {model_ir, model_pc4} = exp;
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    logic [63:0] exp;
    rd = $urandom();
    exp_q.push_back({rd, 32'h0000_0000});
    exp_valid_cnt++;
    start_fetch(32'hFFFF_FFFC);
    pulse_ack(rd);
    checks++;
    if (ir_valid_o !== 1'b1 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL wrap_valid: ir_valid=%b, required 1", ir_valid_o);
    end else begin
      exp = exp_q.pop_front();
      if ({ir_o, pc4_o} !== exp) begin
        errors++;
        $display("FAIL wrap_pc4: ir/pc4=%h, required %h", {ir_o, pc4_o}, exp);
      end
      {model_ir, model_pc4} = exp;
    end
    tick();
  endtask

  task automatic test_stray_ack();
    int v0;
    v0 = valid_cnt;
    for (int i = 0; i < 3; i++) pulse_ack($urandom());
    checks++;
    if (valid_cnt != v0 || ir_o !== model_ir || pc4_o !== model_pc4 || state_o !== ST_IDLE) begin
      errors++;
      $display("FAIL stray_ack_idle: pulses=%0d ir=%h pc4=%h state=%0d, required pulses=0 ir=%h pc4=%h IDLE",
               valid_cnt - v0, ir_o, pc4_o, state_o, model_ir, model_pc4);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    logic [31:0] rd;
    logic [63:0] exp;
    int d;
    for (int i = 0; i < 6; i++) begin
      pc = $urandom() & 32'hFFFF_FFFC;
      rd = $urandom();
      d = $urandom_range(0, 5);
      exp_q.push_back({rd, pc + 32'd4});
      exp_valid_cnt++;
      start_fetch(pc);
      checks++;
      if (mem_req_o !== 1'b1 || mem_addr_o !== pc) begin
        errors++;
        $display("FAIL b2b_req[%0d]: req=%b addr=%h, required req=1 addr=%h", i, mem_req_o, mem_addr_o, pc);
      end
      repeat (d) tick();
      pulse_ack(rd);
      checks++;
      if (ir_valid_o !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_valid[%0d]: ir_valid=%b, required 1", i, ir_valid_o);
      end else begin
        exp = exp_q.pop_front();
        if ({ir_o, pc4_o} !== exp) begin
          errors++;
          $display("FAIL b2b_data[%0d]: ir/pc4=%h, required %h", i, {ir_o, pc4_o}, exp);
        end
        {model_ir, model_pc4} = exp;
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_req();
    start_fetch(32'h0000_4000);
    tick();
    tick();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req_o, ir_valid_o, busy_o, fetch_err_o, state_o} !== 6'b0 ||
        mem_addr_o !== 32'h0 || ir_o !== 32'h0 || pc4_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_req: req=%b valid=%b busy=%b err=%b addr=%h ir=%h pc4=%h, required all zero",
               mem_req_o, ir_valid_o, busy_o, fetch_err_o, mem_addr_o, ir_o, pc4_o);
    end
    model_ir = '0;
    model_pc4 = '0;
    tick();
    rst_n = 1'b1;
    pulse_ack(32'hCAFE_F00D);
    checks++;
    if (ir_valid_o !== 1'b0 || mem_req_o !== 1'b0 || ir_o !== 32'h0 || pc4_o !== 32'h0 || state_o !== ST_IDLE) begin
      errors++;
      $display("FAIL late_ack_ignored: valid=%b req=%b ir=%h pc4=%h state=%0d, required 0 0 0 0 IDLE",
               ir_valid_o, mem_req_o, ir_o, pc4_o, state_o);
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_basic();
    test_misaligned();
    test_timeout_busy();
    test_ack_at_expiry();
    test_wrap();
    test_stray_ack();
    test_back_to_back();
    test_reset_mid_req();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    checks++;
    if (valid_cnt != exp_valid_cnt || err_cnt != exp_err_cnt) begin
      errors++;
      $display("FAIL pulse_totals: ir_valid=%0d fetch_err=%0d, required %0d %0d",
               valid_cnt, err_cnt, exp_valid_cnt, exp_err_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
